// File: rtl/mips_pkg.sv
// mips_pkg
//   Types and encodings shared by the main decoder and the ID/EX pipeline
//   register. ctrl_t carries the per-instruction control bits that travel
//   down the pipeline next to the operands.
package mips_pkg;

    // ALU operation class produced by the main decoder.
    localparam logic [1:0] ALUOP_LW_SW = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic       alusrc;
        logic       regdst;
        logic [1:0] aluop;
    } ctrl_t;

    // A bubble carries no side effects at all.
    localparam ctrl_t CTRL_NOP = '0;

    // Only loads write memory data back to the register file, so memtoreg
    // alone identifies an instruction whose result is late for its consumer.
    function automatic logic is_load(input ctrl_t ctrl);
        return ctrl.memtoreg;
    endfunction

endpackage

// File: rtl/loaduse_detect.sv
// loaduse_detect
//   Combinational load-use hazard check between the instruction in EX and
//   the one in decode.
//   Ports:
//     valid_ex, ctrl_ex, rt_ex : load candidate in the EX slot
//     valid_dec, rs_dec, rt_dec: consumer candidate in the decode slot
//     hazard                   : decode must wait one cycle for the load
module loaduse_detect
    import mips_pkg::*;
(
    input  logic       valid_ex,
    input  ctrl_t      ctrl_ex,
    input  logic [4:0] rt_ex,
    input  logic       valid_dec,
    input  logic [4:0] rs_dec,
    input  logic [4:0] rt_dec,
    output logic       hazard
);

    logic src_match;

    // $zero is hard-wired, so a "load" into it never produces a dependency.
    assign src_match = (rt_ex == rs_dec) || (rt_ex == rt_dec);
    assign hazard    = valid_ex && is_load(ctrl_ex) && (rt_ex != 5'd0)
                       && valid_dec && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register with load-use bubble insertion, flush squash,
//   downstream hold and a saturating count of hazard bubbles.
//   Ports:
//     clk, reset_n            : clock, synchronous active-low reset
//     *_DEC                   : decode-slot instruction (controls, specifiers,
//                               operands, immediate, PC+4, valid)
//     flush_DEC               : squash the decode-slot instruction
//     hold_EX                 : freeze the EX register
//     *_EX                    : registered copy presented to execute
//     stall_DEC               : upstream (PC, IF/ID) must hold this cycle
//     bubbles                 : saturating count of load-use bubbles
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  ctrl_t           ctrl_DEC,
    input  logic            valid_DEC,
    input  logic [4:0]      rs_DEC,
    input  logic [4:0]      rt_DEC,
    input  logic [4:0]      rd_DEC,
    input  logic [DW-1:0]   rd1_DEC,
    input  logic [DW-1:0]   rd2_DEC,
    input  logic [DW-1:0]   signimm_DEC,
    input  logic [DW-1:0]   pcplus4_DEC,
    input  logic            flush_DEC,
    input  logic            hold_EX,
    output ctrl_t           ctrl_EX,
    output logic            valid_EX,
    output logic [4:0]      rs_EX,
    output logic [4:0]      rt_EX,
    output logic [4:0]      rd_EX,
    output logic [DW-1:0]   rd1_EX,
    output logic [DW-1:0]   rd2_EX,
    output logic [DW-1:0]   signimm_EX,
    output logic [DW-1:0]   pcplus4_EX,
    output logic            stall_DEC,
    output logic [CNTW-1:0] bubbles
);

    localparam logic [CNTW-1:0] BUBBLES_MAX = '1;

    logic hazard;
    logic insert_bubble;
    logic count_bubble;

    loaduse_detect u_loaduse_detect (
        .valid_ex  (valid_EX),
        .ctrl_ex   (ctrl_EX),
        .rt_ex     (rt_EX),
        .valid_dec (valid_DEC),
        .rs_dec    (rs_DEC),
        .rt_dec    (rt_DEC),
        .hazard    (hazard)
    );

    // A flush already discards the decode slot, so a concurrent hazard needs
    // no upstream hold and is not counted: the flush owns that bubble.
    assign stall_DEC     = (hazard && !flush_DEC) || hold_EX;
    assign insert_bubble = flush_DEC || hazard;
    assign count_bubble  = hazard && !flush_DEC;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_EX    <= CTRL_NOP;
            valid_EX   <= 1'b0;
            rs_EX      <= '0;
            rt_EX      <= '0;
            rd_EX      <= '0;
            rd1_EX     <= '0;
            rd2_EX     <= '0;
            signimm_EX <= '0;
            pcplus4_EX <= '0;
            bubbles    <= '0;
        end else if (!hold_EX) begin
            if (insert_bubble) begin
                ctrl_EX    <= CTRL_NOP;
                valid_EX   <= 1'b0;
                rs_EX      <= '0;
                rt_EX      <= '0;
                rd_EX      <= '0;
                rd1_EX     <= '0;
                rd2_EX     <= '0;
                signimm_EX <= '0;
                pcplus4_EX <= '0;
            end else begin
                // An empty decode slot must not carry side-effecting controls.
                ctrl_EX    <= valid_DEC ? ctrl_DEC : CTRL_NOP;
                valid_EX   <= valid_DEC;
                rs_EX      <= rs_DEC;
                rt_EX      <= rt_DEC;
                rd_EX      <= rd_DEC;
                rd1_EX     <= rd1_DEC;
                rd2_EX     <= rd2_DEC;
                signimm_EX <= signimm_DEC;
                pcplus4_EX <= pcplus4_DEC;
            end
            if (count_bubble && (bubbles != BUBBLES_MAX)) begin
                bubbles <= bubbles + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Directed table of cycles with hand-derived expectations, a bubble
//   saturation sequence, then randomized traffic. Every cycle both a default
//   instance and a CNTW=2 instance are compared against a behavioural model.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    ctrl_t         ctrl_DEC;
    logic          valid_DEC;
    logic [4:0]    rs_DEC, rt_DEC, rd_DEC;
    logic [DW-1:0] rd1_DEC, rd2_DEC, signimm_DEC, pcplus4_DEC;
    logic          flush_DEC, hold_EX;

    ctrl_t         ctrl_EX, s_ctrl_EX;
    logic          valid_EX, s_valid_EX;
    logic [4:0]    rs_EX, rt_EX, rd_EX, s_rs_EX, s_rt_EX, s_rd_EX;
    logic [DW-1:0] rd1_EX, rd2_EX, signimm_EX, pcplus4_EX;
    logic [DW-1:0] s_rd1_EX, s_rd2_EX, s_signimm_EX, s_pcplus4_EX;
    logic          stall_DEC, s_stall_DEC;
    logic [15:0]   bubbles;
    logic [1:0]    s_bubbles;

    id_ex_stage #(.DW(DW), .CNTW(16)) dut (
        .clk(clk), .reset_n(reset_n), .ctrl_DEC(ctrl_DEC), .valid_DEC(valid_DEC),
        .rs_DEC(rs_DEC), .rt_DEC(rt_DEC), .rd_DEC(rd_DEC), .rd1_DEC(rd1_DEC),
        .rd2_DEC(rd2_DEC), .signimm_DEC(signimm_DEC), .pcplus4_DEC(pcplus4_DEC),
        .flush_DEC(flush_DEC), .hold_EX(hold_EX), .ctrl_EX(ctrl_EX),
        .valid_EX(valid_EX), .rs_EX(rs_EX), .rt_EX(rt_EX), .rd_EX(rd_EX),
        .rd1_EX(rd1_EX), .rd2_EX(rd2_EX), .signimm_EX(signimm_EX),
        .pcplus4_EX(pcplus4_EX), .stall_DEC(stall_DEC), .bubbles(bubbles)
    );

    id_ex_stage #(.DW(DW), .CNTW(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .ctrl_DEC(ctrl_DEC), .valid_DEC(valid_DEC),
        .rs_DEC(rs_DEC), .rt_DEC(rt_DEC), .rd_DEC(rd_DEC), .rd1_DEC(rd1_DEC),
        .rd2_DEC(rd2_DEC), .signimm_DEC(signimm_DEC), .pcplus4_DEC(pcplus4_DEC),
        .flush_DEC(flush_DEC), .hold_EX(hold_EX), .ctrl_EX(s_ctrl_EX),
        .valid_EX(s_valid_EX), .rs_EX(s_rs_EX), .rt_EX(s_rt_EX), .rd_EX(s_rd_EX),
        .rd1_EX(s_rd1_EX), .rd2_EX(s_rd2_EX), .signimm_EX(s_signimm_EX),
        .pcplus4_EX(s_pcplus4_EX), .stall_DEC(s_stall_DEC), .bubbles(s_bubbles)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: the EX slot as a plain record plus two counters.
    typedef struct packed {
        logic          valid;
        ctrl_t         ctrl;
        logic [4:0]    rs, rt, rd;
        logic [DW-1:0] rd1, rd2, imm, pc4;
    } ex_t;

    ex_t m_ex;
    int  m_bub;
    int  m_bub_s;
    bit  model_ready = 1'b0;

    typedef struct {
        logic        rst_n, hold, flush, valid;
        logic [7:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1, imm;
        logic        exp_stall, exp_valid;
        logic [7:0]  exp_ctrl;
        logic [31:0] exp_rd1;
        int          exp_bub;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic rn, hold, flush, valid,
                                input logic [7:0] ctrl, input logic [4:0] rs, rt, rd,
                                input logic [31:0] rd1, imm,
                                input logic es, ev, input logic [7:0] ec,
                                input logic [31:0] erd1, input int eb);
        vec_t v;
        v.rst_n = rn; v.hold = hold; v.flush = flush; v.valid = valid;
        v.ctrl = ctrl; v.rs = rs; v.rt = rt; v.rd = rd; v.rd1 = rd1; v.imm = imm;
        v.exp_stall = es; v.exp_valid = ev; v.exp_ctrl = ec; v.exp_rd1 = erd1;
        v.exp_bub = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hazard();
        return m_ex.valid && m_ex.ctrl.memtoreg && (m_ex.rt != 5'd0) && valid_DEC
               && (m_ex.rt == rs_DEC || m_ex.rt == rt_DEC);
    endfunction

    function automatic logic model_stall();
        return (model_hazard() && !flush_DEC) || hold_EX;
    endfunction

    // Apply the priority reset > hold > flush > hazard > load at one edge.
    task automatic modelEdge();
        logic hz;
        hz = model_hazard();
        if (!reset_n) begin
            m_ex = '0; m_bub = 0; m_bub_s = 0;
        end else if (hold_EX) begin
            m_ex = m_ex;
        end else if (flush_DEC || hz) begin
            m_ex = '0;
            if (!flush_DEC) begin
                m_bub   = (m_bub   < 65535) ? m_bub + 1   : m_bub;
                m_bub_s = (m_bub_s < 3)     ? m_bub_s + 1 : m_bub_s;
            end
        end else begin
            m_ex.valid = valid_DEC;
            m_ex.ctrl  = valid_DEC ? ctrl_DEC : '0;
            m_ex.rs = rs_DEC; m_ex.rt = rt_DEC; m_ex.rd = rd_DEC;
            m_ex.rd1 = rd1_DEC; m_ex.rd2 = rd2_DEC;
            m_ex.imm = signimm_DEC; m_ex.pc4 = pcplus4_DEC;
        end
        if (!reset_n) model_ready = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset_n     = v.rst_n;
        hold_EX     = v.hold;
        flush_DEC   = v.flush;
        valid_DEC   = v.valid;
        ctrl_DEC    = ctrl_t'(v.ctrl);
        rs_DEC      = v.rs;
        rt_DEC      = v.rt;
        rd_DEC      = v.rd;
        rd1_DEC     = v.rd1;
        rd2_DEC     = v.rd1 ^ 32'h0000_FFFF;
        signimm_DEC = v.imm;
        pcplus4_DEC = v.rd1 + 32'd4;
        #1;
    endtask

    task automatic checkOutput();
        check("valid_EX", 64'(valid_EX), 64'(m_ex.valid));
        check("ctrl_EX", 64'(ctrl_EX), 64'(m_ex.ctrl));
        check("rs_EX", 64'(rs_EX), 64'(m_ex.rs));
        check("rt_EX", 64'(rt_EX), 64'(m_ex.rt));
        check("rd_EX", 64'(rd_EX), 64'(m_ex.rd));
        check("rd1_EX", 64'(rd1_EX), 64'(m_ex.rd1));
        check("rd2_EX", 64'(rd2_EX), 64'(m_ex.rd2));
        check("signimm_EX", 64'(signimm_EX), 64'(m_ex.imm));
        check("pcplus4_EX", 64'(pcplus4_EX), 64'(m_ex.pc4));
        check("bubbles", 64'(bubbles), 64'(m_bub));
        check("sat_valid_EX", 64'(s_valid_EX), 64'(m_ex.valid));
        check("sat_ctrl_EX", 64'(s_ctrl_EX), 64'(m_ex.ctrl));
        check("sat_rs_EX", 64'(s_rs_EX), 64'(m_ex.rs));
        check("sat_rt_EX", 64'(s_rt_EX), 64'(m_ex.rt));
        check("sat_rd_EX", 64'(s_rd_EX), 64'(m_ex.rd));
        check("sat_rd1_EX", 64'(s_rd1_EX), 64'(m_ex.rd1));
        check("sat_rd2_EX", 64'(s_rd2_EX), 64'(m_ex.rd2));
        check("sat_signimm_EX", 64'(s_signimm_EX), 64'(m_ex.imm));
        check("sat_pcplus4_EX", 64'(s_pcplus4_EX), 64'(m_ex.pc4));
        check("sat_bubbles", 64'(s_bubbles), 64'(m_bub_s));
        if (!valid_EX) begin
            check("empty_slot_side_effects",
                  64'({ctrl_EX.regwrite, ctrl_EX.memwrite, ctrl_EX.branch}), 64'(0));
        end
    endtask

    // One cycle: stall checked before the edge, registers checked #1 after it.
    task automatic stepCycle();
        if (model_ready) begin
            check("stall_DEC", 64'(stall_DEC), 64'(model_stall()));
            check("sat_stall_DEC", 64'(s_stall_DEC), 64'(model_stall()));
        end
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        vec_t v;

        //      rn h f v ctrl   rs rt rd rd1      imm   es ev ec     erd1     eb
        tbl[0]  = mk(0,0,0,0,8'h00, 0, 0, 0, 32'h00, 0,  0, 0, 8'h00, 32'h00, 0);
        tbl[1]  = mk(0,1,0,0,8'h00, 0, 0, 0, 32'h00, 0,  1, 0, 8'h00, 32'h00, 0);
        tbl[2]  = mk(1,0,0,1,8'h88, 1, 2, 0, 32'h10, 5,  0, 1, 8'h88, 32'h10, 0);
        tbl[3]  = mk(1,0,0,1,8'hC8, 1, 8, 0, 32'h20, 4,  0, 1, 8'hC8, 32'h20, 0);
        tbl[4]  = mk(1,0,0,1,8'h86, 8, 3, 9, 32'h30, 0,  1, 0, 8'h00, 32'h00, 1);
        tbl[5]  = mk(1,0,0,1,8'h86, 8, 3, 9, 32'h30, 0,  0, 1, 8'h86, 32'h30, 1);
        tbl[6]  = mk(1,0,0,1,8'hC8, 0, 0, 0, 32'h40, 0,  0, 1, 8'hC8, 32'h40, 1);
        tbl[7]  = mk(1,0,0,1,8'h86, 0, 0, 5, 32'h50, 0,  0, 1, 8'h86, 32'h50, 1);
        tbl[8]  = mk(1,0,0,1,8'hC8, 2, 7, 0, 32'h60, 8,  0, 1, 8'hC8, 32'h60, 1);
        tbl[9]  = mk(1,0,1,1,8'h86, 1, 7, 4, 32'h66, 0,  0, 0, 8'h00, 32'h00, 1);
        tbl[10] = mk(1,0,0,1,8'hC8, 2, 7, 0, 32'h70, 8,  0, 1, 8'hC8, 32'h70, 1);
        tbl[11] = mk(1,1,0,1,8'h86, 7, 1, 4, 32'h77, 0,  1, 1, 8'hC8, 32'h70, 1);
        tbl[12] = mk(1,1,1,1,8'h86, 7, 1, 4, 32'h77, 0,  1, 1, 8'hC8, 32'h70, 1);
        tbl[13] = mk(1,1,0,0,8'h86, 7, 1, 4, 32'h77, 0,  1, 1, 8'hC8, 32'h70, 1);
        tbl[14] = mk(1,0,0,1,8'h86, 7, 1, 4, 32'h77, 0,  1, 0, 8'h00, 32'h00, 2);
        tbl[15] = mk(1,0,0,1,8'hC8, 3, 9, 0, 32'h80, 0,  0, 1, 8'hC8, 32'h80, 2);
        tbl[16] = mk(0,1,0,1,8'h86, 9, 2, 4, 32'h88, 0,  1, 0, 8'h00, 32'h00, 0);
        tbl[17] = mk(1,0,0,0,8'h28, 1, 2, 3, 32'h90, 0,  0, 0, 8'h00, 32'h90, 0);

        m_ex = '0; m_bub = 0; m_bub_s = 0;

        $display("[TB] directed table");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i]);
            if (i > 0) check($sformatf("tbl%0d_stall", i), 64'(stall_DEC), 64'(tbl[i].exp_stall));
            stepCycle();
            check($sformatf("tbl%0d_valid", i), 64'(valid_EX), 64'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_ctrl", i), 64'(ctrl_EX), 64'(tbl[i].exp_ctrl));
            check($sformatf("tbl%0d_rd1", i), 64'(rd1_EX), 64'(tbl[i].exp_rd1));
            check($sformatf("tbl%0d_bubbles", i), 64'(bubbles), 64'(tbl[i].exp_bub));
        end

        // Self-dependent load repeated: hazard on every second edge, five in all.
        $display("[TB] bubble saturation sequence");
        applyStimulus(mk(0,0,0,0,8'h00,0,0,0,0,0, 0,0,8'h00,0,0));
        stepCycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(mk(1,0,0,1,8'hC8,5,5,0,32'h100 + 32'(i),0, 0,0,8'h00,0,0));
            stepCycle();
        end
        check("sat_seq_bubbles", 64'(bubbles), 64'(5));
        check("sat_seq_small_bubbles", 64'(s_bubbles), 64'(3));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            v.rst_n = ($urandom_range(0, 99) >= 3);
            v.hold  = ($urandom_range(0, 99) < 12);
            v.flush = ($urandom_range(0, 99) < 10);
            v.valid = ($urandom_range(0, 99) < 85);
            v.ctrl  = 8'($urandom);
            v.rs    = 5'($urandom_range(0, 3));
            v.rt    = 5'($urandom_range(0, 3));
            v.rd    = 5'($urandom);
            v.rd1   = $urandom;
            v.imm   = $urandom;
            v.exp_stall = 1'b0; v.exp_valid = 1'b0; v.exp_ctrl = '0;
            v.exp_rd1 = '0; v.exp_bub = 0;
            applyStimulus(v);
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
